vga_timing_receiver: RTL and testbench
======================================

VGA_TIMING_RECEIVER -- requirements
Module: vga_timing_receiver

Interface
REQ-001 SHALL have parameter EXP_H_TOTAL, default 800: expected clocks per line.
REQ-002 SHALL have parameter EXP_H_ACTIVE, default 640: expected DE-high clocks per active line.
REQ-003 SHALL have parameter EXP_V_TOTAL, default 525: expected lines per frame.
REQ-004 SHALL have parameter EXP_V_ACTIVE, default 480: expected active lines per frame.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2: consecutive good frames required to lock.
REQ-006 SHALL have port clock  input  1  pixel clock (25 MHz); all logic on its rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high.
REQ-008 SHALL have port hsync_in  input  1  horizontal sync, active-low pulse.
REQ-009 SHALL have port vsync_in  input  1  vertical sync, active-low pulse.
REQ-010 SHALL have port de_in  input  1  data enable, high on active pixels.
REQ-011 SHALL have port pixel_in  input  8  pixel colour, RRRGGGBB.
REQ-012 SHALL have port pixel_valid  output  1  registered DE, aligned with pixel_out/x/y.
REQ-013 SHALL have port pixel_out  output  8  recovered pixel colour.
REQ-014 SHALL have port x  output  10  column index of pixel_out within the active line.
REQ-015 SHALL have port y  output  10  active-line index of pixel_out within the frame.
REQ-016 SHALL have port line_start  output  1  one-cycle pulse with x==0.
REQ-017 SHALL have port frame_start  output  1  one-cycle pulse with x==0 and y==0.
REQ-018 SHALL have port h_total  output  10  measured clocks in the last completed line.
REQ-019 SHALL have port h_active  output  10  DE-high clocks in the last completed line.
REQ-020 SHALL have port v_total  output  10  lines in the last completed frame.
REQ-021 SHALL have port v_active  output  10  lines with nonzero DE count in the last completed frame.
REQ-022 SHALL have port locked  output  1  timing matches all EXP_* values.
REQ-023 SHALL have port timing_error  output  1  one-cycle pulse on mismatch detection while locked.

Function
REQ-024 SHALL register hsync_in, vsync_in, de_in, pixel_in once (stage 1); hs_fall/vs_fall = stage-1 value 0 with previous stage-1 value 1.
REQ-025 SHALL drive pixel_valid/pixel_out/x/y/line_start/frame_start two clocks after the corresponding input sample.
REQ-026 SHALL reset x to 0 on each DE rising edge and increment x per DE-high clock; y resets to 0 at vs_fall and increments at each DE falling edge; both saturate at 1023.
REQ-027 SHALL count clocks since the last hs_fall (saturating at 1023); at hs_fall, h_total <= count+1 (saturating) and h_active <= DE-high count for that line, both updating on the following edge.
REQ-028 SHALL count hs_fall events and lines with h_active>0 since the last vs_fall; at vs_fall, latch them into v_total and v_active.
REQ-029 SHALL, when hs_fall and vs_fall occur in the same cycle, credit the closing line to the closing frame.
REQ-030 SHALL implement states SEARCH, MEASURE, LOCKED; SEARCH -> MEASURE on first vs_fall, discarding partial-frame results.
REQ-031 SHALL treat a frame as good iff every line had h_total==EXP_H_TOTAL, every nonzero h_active==EXP_H_ACTIVE, v_total==EXP_V_TOTAL, v_active==EXP_V_ACTIVE.
REQ-032 SHALL in MEASURE at vs_fall: good frame -> good_cnt+1, reaching LOCK_FRAMES -> LOCKED; bad frame -> good_cnt=0.
REQ-033 SHALL in LOCKED: on a line mismatch at hs_fall or a frame mismatch at vs_fall, go to MEASURE, clear good_cnt, pulse timing_error one cycle.
REQ-034 SHALL assert locked exactly when the state is LOCKED, changing on the same edge as the state.
REQ-035 SHALL never pulse timing_error in SEARCH or MEASURE.

Reset
REQ-036 SHALL, on reset (including mid-frame), zero all outputs, counters, pipeline registers and good_cnt, and enter SEARCH on the next edge.

Verification
REQ-037 SHALL cover: ideal 800x525 stream -> locked rises at the 3rd vs_fall after reset (1st enters MEASURE); h_total=800, h_active=640, v_total=525, v_active=480.
REQ-038 SHALL cover: pixel_in=0xA5 at column 5 of active line 7 -> 2 clocks later pixel_out=0xA5, x=5, y=7, pixel_valid=1.
REQ-039 SHALL cover: while locked, inject one 801-clock line -> h_total=801, one-cycle timing_error, locked=0, relock after 2 good frames.
REQ-040 SHALL cover: reset asserted mid-frame while locked -> all outputs 0 next edge; relock needs 3 vs_falls.
REQ-041 SHALL cover: hs_fall coincident with vs_fall -> v_total=525, locked unaffected.
REQ-042 SHALL cover: hsync_in stuck high -> clock count saturates, h_total not updated, locked=0, timing_error never pulses.

Source files
------------

// File: rtl/vga_timing_receiver.sv
// VGA timing receiver: recovers pixel coordinates from hsync/vsync/DE and measures line/frame
// geometry, locking once the measured timing matches the expected mode for several frames.
module vga_timing_receiver #(
  parameter int unsigned EXP_H_TOTAL  = 800,
  parameter int unsigned EXP_H_ACTIVE = 640,
  parameter int unsigned EXP_V_TOTAL  = 525,
  parameter int unsigned EXP_V_ACTIVE = 480,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       de_in,
  input  logic [7:0] pixel_in,
  output logic       pixel_valid,
  output logic [7:0] pixel_out,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] h_total,
  output logic [9:0] h_active,
  output logic [9:0] v_total,
  output logic [9:0] v_active,
  output logic       locked,
  output logic       timing_error
);

  localparam logic [1:0] StSearch  = 2'd0;
  localparam logic [1:0] StMeasure = 2'd1;
  localparam logic [1:0] StLocked  = 2'd2;

  localparam logic [9:0] ExpHTotal  = EXP_H_TOTAL[9:0];
  localparam logic [9:0] ExpHActive = EXP_H_ACTIVE[9:0];
  localparam logic [9:0] ExpVTotal  = EXP_V_TOTAL[9:0];
  localparam logic [9:0] ExpVActive = EXP_V_ACTIVE[9:0];
  localparam logic [7:0] LockFrames = LOCK_FRAMES[7:0];

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  // Stage-1 samples and their previous values for edge detection
  logic       hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
  logic       hs1p_q, hs1p_d, vs1p_q, vs1p_d, de1p_q, de1p_d;
  logic [7:0] pix1_q, pix1_d;

  logic       pixel_valid_q, pixel_valid_d;
  logic [7:0] pixel_out_q, pixel_out_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic       line_start_q, line_start_d, frame_start_q, frame_start_d;

  logic [9:0] h_cnt_q, h_cnt_d, de_cnt_q, de_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d, va_cnt_q, va_cnt_d;
  logic [9:0] h_total_q, h_total_d, h_active_q, h_active_d;
  logic [9:0] v_total_q, v_total_d, v_active_q, v_active_d;
  logic       frame_ok_q, frame_ok_d;
  logic [1:0] state_q, state_d;
  logic [7:0] good_cnt_q, good_cnt_d;
  logic       timing_error_q, timing_error_d;

  logic       hs_fall, vs_fall, de_rise, de_fall;
  logic [9:0] line_h_total, line_h_active, frame_v_total, frame_v_active;
  logic       line_ok, frame_good;

  always_comb begin
    hs_fall = ~hs1_q & hs1p_q;
    vs_fall = ~vs1_q & vs1p_q;
    de_rise = de1_q & ~de1p_q;
    de_fall = ~de1_q & de1p_q;

    hs1_d  = hsync_in;
    vs1_d  = vsync_in;
    de1_d  = de_in;
    pix1_d = pixel_in;
    hs1p_d = hs1_q;
    vs1p_d = vs1_q;
    de1p_d = de1_q;

    pixel_valid_d = de1_q;
    pixel_out_d   = pix1_q;
    x_d = x_q;
    if (de_rise) begin
      x_d = 10'd0;
    end else if (de1_q) begin
      x_d = sat_inc(x_q);
    end
    y_d = y_q;
    if (vs_fall) begin
      y_d = 10'd0;
    end else if (de_fall) begin
      y_d = sat_inc(y_q);
    end
    line_start_d  = de_rise;
    frame_start_d = de_rise && (y_d == 10'd0);

    // The hs_fall cycle itself is the last cycle of the closing line
    line_h_total  = sat_inc(h_cnt_q);
    line_h_active = de1_q ? sat_inc(de_cnt_q) : de_cnt_q;
    line_ok = (line_h_total == ExpHTotal) &&
              ((line_h_active == 10'd0) || (line_h_active == ExpHActive));

    h_cnt_d    = hs_fall ? 10'd0 : sat_inc(h_cnt_q);
    de_cnt_d   = hs_fall ? 10'd0 : (de1_q ? sat_inc(de_cnt_q) : de_cnt_q);
    h_total_d  = hs_fall ? line_h_total : h_total_q;
    h_active_d = hs_fall ? line_h_active : h_active_q;

    // A line closing on the same cycle as vs_fall belongs to the closing frame
    frame_v_total  = hs_fall ? sat_inc(v_cnt_q) : v_cnt_q;
    frame_v_active = (hs_fall && (line_h_active != 10'd0)) ? sat_inc(va_cnt_q) : va_cnt_q;
    frame_good = frame_ok_q && (!hs_fall || line_ok) &&
                 (frame_v_total == ExpVTotal) && (frame_v_active == ExpVActive);

    v_cnt_d    = v_cnt_q;
    va_cnt_d   = va_cnt_q;
    frame_ok_d = frame_ok_q;
    v_total_d  = v_total_q;
    v_active_d = v_active_q;
    if (vs_fall) begin
      v_cnt_d    = 10'd0;
      va_cnt_d   = 10'd0;
      frame_ok_d = 1'b1;
      v_total_d  = frame_v_total;
      v_active_d = frame_v_active;
    end else if (hs_fall) begin
      v_cnt_d    = frame_v_total;
      va_cnt_d   = frame_v_active;
      frame_ok_d = frame_ok_q && line_ok;
    end

    state_d        = state_q;
    good_cnt_d     = good_cnt_q;
    timing_error_d = 1'b0;
    case (state_q)
      StSearch: begin
        if (vs_fall) begin
          state_d    = StMeasure;
          good_cnt_d = 8'd0;
        end
      end
      StMeasure: begin
        if (vs_fall) begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 8'd1;
            if (good_cnt_q + 8'd1 >= LockFrames) begin
              state_d = StLocked;
            end
          end else begin
            good_cnt_d = 8'd0;
          end
        end
      end
      StLocked: begin
        if ((hs_fall && !line_ok) || (vs_fall && !frame_good)) begin
          state_d        = StMeasure;
          good_cnt_d     = 8'd0;
          timing_error_d = 1'b1;
        end
      end
      default: begin
        state_d    = StSearch;
        good_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hs1_q          <= 1'b0;
      vs1_q          <= 1'b0;
      de1_q          <= 1'b0;
      pix1_q         <= 8'd0;
      hs1p_q         <= 1'b0;
      vs1p_q         <= 1'b0;
      de1p_q         <= 1'b0;
      pixel_valid_q  <= 1'b0;
      pixel_out_q    <= 8'd0;
      x_q            <= 10'd0;
      y_q            <= 10'd0;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      h_cnt_q        <= 10'd0;
      de_cnt_q       <= 10'd0;
      v_cnt_q        <= 10'd0;
      va_cnt_q       <= 10'd0;
      h_total_q      <= 10'd0;
      h_active_q     <= 10'd0;
      v_total_q      <= 10'd0;
      v_active_q     <= 10'd0;
      frame_ok_q     <= 1'b0;
      state_q        <= StSearch;
      good_cnt_q     <= 8'd0;
      timing_error_q <= 1'b0;
    end else begin
      hs1_q          <= hs1_d;
      vs1_q          <= vs1_d;
      de1_q          <= de1_d;
      pix1_q         <= pix1_d;
      hs1p_q         <= hs1p_d;
      vs1p_q         <= vs1p_d;
      de1p_q         <= de1p_d;
      pixel_valid_q  <= pixel_valid_d;
      pixel_out_q    <= pixel_out_d;
      x_q            <= x_d;
      y_q            <= y_d;
      line_start_q   <= line_start_d;
      frame_start_q  <= frame_start_d;
      h_cnt_q        <= h_cnt_d;
      de_cnt_q       <= de_cnt_d;
      v_cnt_q        <= v_cnt_d;
      va_cnt_q       <= va_cnt_d;
      h_total_q      <= h_total_d;
      h_active_q     <= h_active_d;
      v_total_q      <= v_total_d;
      v_active_q     <= v_active_d;
      frame_ok_q     <= frame_ok_d;
      state_q        <= state_d;
      good_cnt_q     <= good_cnt_d;
      timing_error_q <= timing_error_d;
    end
  end

  assign pixel_valid  = pixel_valid_q;
  assign pixel_out    = pixel_out_q;
  assign x            = x_q;
  assign y            = y_q;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign h_total      = h_total_q;
  assign h_active     = h_active_q;
  assign v_total      = v_total_q;
  assign v_active     = v_active_q;
  assign locked       = (state_q == StLocked);
  assign timing_error = timing_error_q;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Bench for vga_timing_receiver using a scaled-down 50x24 video mode (32x16 active).
module tb_vga_timing_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic       de_in = 1'b0;
  logic [7:0] pixel_in = 8'd0;
  logic       pixel_valid, line_start, frame_start, locked, timing_error;
  logic [7:0] pixel_out;
  logic [9:0] x, y, h_total, h_active, v_total, v_active;

  vga_timing_receiver #(
    .EXP_H_TOTAL (50),
    .EXP_H_ACTIVE(32),
    .EXP_V_TOTAL (24),
    .EXP_V_ACTIVE(16),
    .LOCK_FRAMES (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .de_in       (de_in),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_out   (pixel_out),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start),
    .h_total     (h_total),
    .h_active    (h_active),
    .v_total     (v_total),
    .v_active    (v_active),
    .locked      (locked),
    .timing_error(timing_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int te_cnt = 0;
  int te_base;

  // Generator position and knobs
  int vc = 0, hc = 0, last_l = 0, last_c = 0;
  int vs_col = 0;
  int extra_line = -1;
  logic hs_stuck = 1'b0;

  always @(negedge clock) if (timing_error === 1'b1) te_cnt++;

  typedef struct {
    int l; int c; int v; int p; int x; int y; int ls; int fs;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " pixel_valid"}, int'(pixel_valid), 0);
    chk({tag, " pixel_out"}, int'(pixel_out), 0);
    chk({tag, " x"}, int'(x), 0);
    chk({tag, " y"}, int'(y), 0);
    chk({tag, " line_start"}, int'(line_start), 0);
    chk({tag, " frame_start"}, int'(frame_start), 0);
    chk({tag, " h_total"}, int'(h_total), 0);
    chk({tag, " h_active"}, int'(h_active), 0);
    chk({tag, " v_total"}, int'(v_total), 0);
    chk({tag, " v_active"}, int'(v_active), 0);
    chk({tag, " locked"}, int'(locked), 0);
    chk({tag, " timing_error"}, int'(timing_error), 0);
  endtask

  task automatic step();
    logic vs_low;
    vs_low = (vc > 18 || (vc == 18 && hc >= vs_col)) && (vc < 20 || (vc == 20 && hc < vs_col));
    de_in    = (vc < 16) && (hc < 32);
    hsync_in = hs_stuck ? 1'b1 : !(hc >= 36 && hc < 42);
    vsync_in = !vs_low;
    if (!de_in) pixel_in = 8'd0;
    else if (vc == 7 && hc == 5) pixel_in = 8'hA5;
    else pixel_in = 8'(((vc % 8) * 32) + hc);
    @(posedge clock);
    #1;
    last_l = vc;
    last_c = hc;
    hc++;
    if (hc >= ((vc == extra_line) ? 51 : 50)) begin
      hc = 0;
      vc = (vc == 23) ? 0 : vc + 1;
    end
  endtask

  task automatic run_to(input int l, input int c);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(last_l == l && last_c == c) && n < 3000);
    if (!(last_l == l && last_c == c)) begin
      $display("FAIL run_to(%0d,%0d): position not reached, got (%0d,%0d)", l, c, last_l, last_c);
      $fatal(1, "generator timeout");
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    de_in    = 1'b0;
    pixel_in = 8'd0;
    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    vc = 0;
    hc = 0;
  endtask

  initial begin
    tbl[0] = '{l: 0,  c: 0,  v: 1, p: 'h00, x: 0,  y: 0,  ls: 1, fs: 1};
    tbl[1] = '{l: 0,  c: 1,  v: 1, p: 'h01, x: 1,  y: 0,  ls: 0, fs: 0};
    tbl[2] = '{l: 0,  c: 31, v: 1, p: 'h1F, x: 31, y: 0,  ls: 0, fs: 0};
    tbl[3] = '{l: 0,  c: 32, v: 0, p: 'h00, x: 31, y: 1,  ls: 0, fs: 0};
    tbl[4] = '{l: 1,  c: 0,  v: 1, p: 'h20, x: 0,  y: 1,  ls: 1, fs: 0};
    tbl[5] = '{l: 7,  c: 4,  v: 1, p: 'hE4, x: 4,  y: 7,  ls: 0, fs: 0};
    tbl[6] = '{l: 7,  c: 5,  v: 1, p: 'hA5, x: 5,  y: 7,  ls: 0, fs: 0};
    tbl[7] = '{l: 15, c: 31, v: 1, p: 'hFF, x: 31, y: 15, ls: 0, fs: 0};
    tbl[8] = '{l: 16, c: 0,  v: 0, p: 'h00, x: 31, y: 16, ls: 0, fs: 0};
    tbl[9] = '{l: 18, c: 0,  v: 0, p: 'h00, x: 31, y: 0,  ls: 0, fs: 0};

    // Ideal stream: first vs_fall enters MEASURE, lock on the third
    do_reset();
    te_base = te_cnt;
    run_to(18, 0);
    run_to(18, 0);
    run_to(3, 40);
    chk("ideal h_total", int'(h_total), 50);
    chk("ideal h_active", int'(h_active), 32);
    chk("ideal locked before 3rd vs", int'(locked), 0);
    run_to(18, 0);
    chk("ideal locked at 3rd vs", int'(locked), 0);
    run_to(18, 1);
    chk("ideal locked after 3rd vs", int'(locked), 1);
    chk("ideal v_total", int'(v_total), 24);
    chk("ideal v_active", int'(v_active), 16);
    chk("ideal no timing_error", te_cnt - te_base, 0);

    // Pixel pipeline vectors; outputs for (l,c) are visible after position (l,c+1)
    for (int i = 0; i < 10; i++) begin
      run_to(tbl[i].l, tbl[i].c + 1);
      chk($sformatf("vec%0d pixel_valid", i), int'(pixel_valid), tbl[i].v);
      chk($sformatf("vec%0d pixel_out", i), int'(pixel_out), tbl[i].p);
      chk($sformatf("vec%0d x", i), int'(x), tbl[i].x);
      chk($sformatf("vec%0d y", i), int'(y), tbl[i].y);
      chk($sformatf("vec%0d line_start", i), int'(line_start), tbl[i].ls);
      chk($sformatf("vec%0d frame_start", i), int'(frame_start), tbl[i].fs);
    end

    // One 51-clock line while locked
    run_to(23, 49);
    extra_line = 5;
    te_base = te_cnt;
    run_to(6, 36);
    chk("long line locked before", int'(locked), 1);
    run_to(6, 37);
    chk("long line h_total", int'(h_total), 51);
    chk("long line timing_error", int'(timing_error), 1);
    chk("long line locked drop", int'(locked), 0);
    run_to(6, 38);
    chk("long line te one cycle", int'(timing_error), 0);
    extra_line = -1;
    run_to(18, 1);
    run_to(18, 1);
    chk("relock after 1 good frame", int'(locked), 0);
    run_to(18, 0);
    chk("relock before 2nd good frame", int'(locked), 0);
    run_to(18, 1);
    chk("relock after 2 good frames", int'(locked), 1);
    chk("long line te count", te_cnt - te_base, 1);

    // Mid-frame reset while locked
    run_to(5, 9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_zero("mid reset");
    te_base = te_cnt;
    run_to(18, 1);
    chk("mid reset 1st vs", int'(locked), 0);
    run_to(18, 1);
    chk("mid reset 2nd vs", int'(locked), 0);
    run_to(18, 0);
    chk("mid reset before 3rd vs", int'(locked), 0);
    run_to(18, 1);
    chk("mid reset after 3rd vs", int'(locked), 1);
    chk("mid reset no te", te_cnt - te_base, 0);

    // vs_fall coincident with hs_fall
    do_reset();
    vs_col = 36;
    te_base = te_cnt;
    run_to(18, 36);
    run_to(18, 36);
    run_to(18, 36);
    chk("coinc locked before", int'(locked), 0);
    run_to(18, 37);
    chk("coinc locked", int'(locked), 1);
    chk("coinc v_total", int'(v_total), 24);
    chk("coinc v_active", int'(v_active), 16);
    run_to(18, 37);
    chk("coinc stays locked", int'(locked), 1);
    chk("coinc no te", te_cnt - te_base, 0);

    // hsync stuck high
    do_reset();
    vs_col = 0;
    hs_stuck = 1'b1;
    te_base = te_cnt;
    run_to(23, 49);
    run_to(23, 49);
    chk("stuck h_total", int'(h_total), 0);
    chk("stuck locked", int'(locked), 0);
    chk("stuck no te", te_cnt - te_base, 0);
    hs_stuck = 1'b0;
    run_to(0, 37);
    chk("stuck saturated h_total", int'(h_total), 1023);
    chk("stuck locked after release", int'(locked), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
